// File: rtl/dataio_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dataio_mem_responder_if
// Description : Bundles the load/store request channel, the memory command
//               channel, the memory read-return channel and the flush line of
//               dataio_mem_responder.
//               slave  - view of the responder itself
//               master - view of the surrounding load/store unit and memory
// Ports       : iFREE_EX, iDATAIO_* (request), oDATAIO_* (response/busy),
//               oMEM_* / iMEM_LOCK (command), iMEM_VALID / iMEM_DATA (return),
//               oERR_TIMEOUT (read timeout pulse)
// Revision    : 1.0 - initial release
// ============================================================================
interface dataio_mem_responder_if;
    logic        iFREE_EX;
    logic        iDATAIO_REQ;
    logic        oDATAIO_BUSY;
    logic [1:0]  iDATAIO_ORDER;
    logic        iDATAIO_RW;
    logic [13:0] iDATAIO_TID;
    logic [1:0]  iDATAIO_MMUMOD;
    logic [31:0] iDATAIO_PDT;
    logic [31:0] iDATAIO_ADDR;
    logic [31:0] iDATAIO_DATA;
    logic        oDATAIO_REQ;
    logic [31:0] oDATAIO_DATA;
    logic        oMEM_VALID;
    logic        iMEM_LOCK;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [3:0]  oMEM_BE;
    logic [31:0] oMEM_DATA;
    logic [13:0] oMEM_TID;
    logic [1:0]  oMEM_MMUMOD;
    logic [31:0] oMEM_PDT;
    logic        iMEM_VALID;
    logic [31:0] iMEM_DATA;
    logic        oERR_TIMEOUT;

    modport slave (
        input  iFREE_EX, iDATAIO_REQ, iDATAIO_ORDER, iDATAIO_RW, iDATAIO_TID,
               iDATAIO_MMUMOD, iDATAIO_PDT, iDATAIO_ADDR, iDATAIO_DATA,
               iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        output oDATAIO_BUSY, oDATAIO_REQ, oDATAIO_DATA, oMEM_VALID, oMEM_RW,
               oMEM_ADDR, oMEM_BE, oMEM_DATA, oMEM_TID, oMEM_MMUMOD, oMEM_PDT,
               oERR_TIMEOUT
    );

    modport master (
        output iFREE_EX, iDATAIO_REQ, iDATAIO_ORDER, iDATAIO_RW, iDATAIO_TID,
               iDATAIO_MMUMOD, iDATAIO_PDT, iDATAIO_ADDR, iDATAIO_DATA,
               iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        input  oDATAIO_BUSY, oDATAIO_REQ, oDATAIO_DATA, oMEM_VALID, oMEM_RW,
               oMEM_ADDR, oMEM_BE, oMEM_DATA, oMEM_TID, oMEM_MMUMOD, oMEM_PDT,
               oERR_TIMEOUT
    );
endinterface
`default_nettype wire

// File: rtl/dataio_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dataio_mem_responder
// Description : Converts single load/store requests into one aligned memory
//               command (word address, byte enables, lane-shifted write data),
//               returns read data with a one-cycle pulse, and handles pipeline
//               flush and read timeout.
// Ports       : iCLOCK  - clock, rising edge
//               iRESET  - asynchronous active-high reset
//               bus     - dataio_mem_responder_if.slave (all other signals)
// Parameters  : P_TIMEOUT - cycles a read waits for memory data (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module dataio_mem_responder #(
    parameter int P_TIMEOUT = 255
) (
    input  wire                   iCLOCK,
    input  wire                   iRESET,
    dataio_mem_responder_if.slave bus
);
    localparam logic [7:0] c_TO_LIMIT = 8'(P_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [13:0] mem_tid_q, mem_tid_d;
    logic [1:0]  mem_mmumod_q, mem_mmumod_d;
    logic [31:0] mem_pdt_q, mem_pdt_d;
    logic        rsp_req_q, rsp_req_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        err_to_q, err_to_d;

    // Lane placement of the incoming request
    logic [1:0]  w_k;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_cnt_inc;

    assign w_k       = bus.iDATAIO_ADDR[1:0];
    assign w_cnt_inc = cnt_q + 8'd1;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.iDATAIO_DATA;
        case (bus.iDATAIO_ORDER)
            2'd0: begin
                w_be    = 4'b0001 << w_k;
                w_wdata = bus.iDATAIO_DATA << {w_k, 3'b000};
            end
            2'd1: begin
                // Upper half of a k=3 halfword falls off the word
                w_be    = 4'b0011 << w_k;
                w_wdata = bus.iDATAIO_DATA << {w_k, 3'b000};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.iDATAIO_DATA;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_data_d   = mem_data_q;
        mem_tid_d    = mem_tid_q;
        mem_mmumod_d = mem_mmumod_q;
        mem_pdt_d    = mem_pdt_q;
        rsp_req_d    = 1'b0;
        rsp_data_d   = rsp_data_q;
        err_to_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ORDER=3 is accepted but produces nothing
                if (bus.iDATAIO_REQ && !bus.iFREE_EX && (bus.iDATAIO_ORDER != 2'd3)) begin
                    state_d      = S_ISSUE;
                    mem_valid_d  = 1'b1;
                    mem_rw_d     = bus.iDATAIO_RW;
                    mem_addr_d   = {bus.iDATAIO_ADDR[31:2], 2'b00};
                    mem_be_d     = w_be;
                    mem_data_d   = bus.iDATAIO_RW ? w_wdata : 32'h0;
                    mem_tid_d    = bus.iDATAIO_TID;
                    mem_mmumod_d = bus.iDATAIO_MMUMOD;
                    mem_pdt_d    = bus.iDATAIO_PDT;
                end
            end
            S_ISSUE: begin
                // A flushed read is abandoned; a store is committed regardless
                if (bus.iFREE_EX && !mem_rw_q) begin
                    state_d     = S_IDLE;
                    mem_valid_d = 1'b0;
                end else if (!bus.iMEM_LOCK) begin
                    state_d     = mem_rw_q ? S_IDLE : S_WAIT;
                    mem_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                end
            end
            S_WAIT: begin
                if (bus.iFREE_EX) begin
                    // Data arriving with the flush needs no drain phase
                    state_d = bus.iMEM_VALID ? S_IDLE : S_DRAIN;
                    cnt_d   = 8'd0;
                end else if (bus.iMEM_VALID) begin
                    state_d    = S_IDLE;
                    rsp_req_d  = 1'b1;
                    rsp_data_d = bus.iMEM_DATA;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_TO_LIMIT) begin
                        state_d    = S_IDLE;
                        rsp_req_d  = 1'b1;
                        rsp_data_d = 32'h0;
                        err_to_d   = 1'b1;
                    end
                end
            end
            default: begin // S_DRAIN
                if (bus.iMEM_VALID) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_TO_LIMIT) begin
                        state_d  = S_IDLE;
                        err_to_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            mem_valid_q  <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_data_q   <= 32'h0;
            mem_tid_q    <= 14'h0;
            mem_mmumod_q <= 2'h0;
            mem_pdt_q    <= 32'h0;
            rsp_req_q    <= 1'b0;
            rsp_data_q   <= 32'h0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_data_q   <= mem_data_d;
            mem_tid_q    <= mem_tid_d;
            mem_mmumod_q <= mem_mmumod_d;
            mem_pdt_q    <= mem_pdt_d;
            rsp_req_q    <= rsp_req_d;
            rsp_data_q   <= rsp_data_d;
            err_to_q     <= err_to_d;
        end
    end

    assign bus.oDATAIO_BUSY = (state_q != S_IDLE);
    assign bus.oDATAIO_REQ  = rsp_req_q;
    assign bus.oDATAIO_DATA = rsp_data_q;
    assign bus.oMEM_VALID   = mem_valid_q;
    assign bus.oMEM_RW      = mem_rw_q;
    assign bus.oMEM_ADDR    = mem_addr_q;
    assign bus.oMEM_BE      = mem_be_q;
    assign bus.oMEM_DATA    = mem_data_q;
    assign bus.oMEM_TID     = mem_tid_q;
    assign bus.oMEM_MMUMOD  = mem_mmumod_q;
    assign bus.oMEM_PDT     = mem_pdt_q;
    assign bus.oERR_TIMEOUT = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_dataio_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dataio_mem_responder
// Description : Self-checking bench for dataio_mem_responder: directed vector
//               table, hand-written flush/timeout/reset sequences and random
//               transactions checked against a transaction-level model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dataio_mem_responder;
    localparam int C_TO = 4;

    logic iCLOCK;
    logic iRESET;
    int   n_checks = 0;
    int   n_err    = 0;

    dataio_mem_responder_if bus();

    dataio_mem_responder #(.P_TIMEOUT(C_TO)) u_dut (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  order;
        logic        rw;
        int          lock_n;
        int          lat;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lanes touched by a transfer: size in bytes starting at the lane index
    function automatic logic [3:0] ref_be(input logic [1:0] order, input logic [1:0] k);
        int lanes = (order == 2'd0) ? 1 : (order == 2'd1) ? 2 : 4;
        int first = (order == 2'd2) ? 0 : int'(k);
        logic [3:0] m = 4'h0;
        for (int b = 0; b < 4; b++)
            if (b >= first && b < first + lanes) m[b] = 1'b1;
        return m;
    endfunction

    // Byte b of the bus carries source byte (b - first); bytes pushed past lane 3 are lost
    function automatic logic [31:0] ref_wdata(input logic [31:0] data, input logic [1:0] order,
                                              input logic [1:0] k);
        int first = (order == 2'd2) ? 0 : int'(k);
        logic [31:0] r = 32'h0;
        for (int b = 0; b < 4; b++)
            if (b >= first) r[8*b +: 8] = data[8*(b-first) +: 8];
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(bus.oDATAIO_BUSY), 32'h0);
        check({tag, "_rsp"},    32'(bus.oDATAIO_REQ),  32'h0);
        check({tag, "_rdata"},  bus.oDATAIO_DATA,      32'h0);
        check({tag, "_mvalid"}, 32'(bus.oMEM_VALID),   32'h0);
        check({tag, "_err"},    32'(bus.oERR_TIMEOUT), 32'h0);
        check({tag, "_maddr"},  bus.oMEM_ADDR,         32'h0);
        check({tag, "_mdata"},  bus.oMEM_DATA,         32'h0);
        check({tag, "_mpdt"},   bus.oMEM_PDT,          32'h0);
        check({tag, "_mmisc"}, 32'({bus.oMEM_BE, bus.oMEM_TID, bus.oMEM_MMUMOD, bus.oMEM_RW}), 32'h0);
    endtask

    // One full transaction. flush_mode: 0 none, 1 flush in first ISSUE cycle,
    // 2 flush after flush_at WAIT cycles (then lat is the drain latency).
    // lat >= C_TO means memory never answers.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] order, input logic rw,
                           input logic [3:0] xbe, input logic [31:0] xdata,
                           input int lock_n, input int lat, input int flush_mode,
                           input int flush_at, input logic [31:0] rdata);
        logic [13:0] tid    = 14'($urandom);
        logic [1:0]  mmumod = 2'($urandom);
        logic [31:0] pdt    = $urandom;
        logic        drain  = (flush_mode == 2);
        logic        x_rsp, x_err;
        logic [31:0] x_data;

        bus.iDATAIO_REQ    = 1'b1;
        bus.iDATAIO_ADDR   = addr;
        bus.iDATAIO_DATA   = data;
        bus.iDATAIO_ORDER  = order;
        bus.iDATAIO_RW     = rw;
        bus.iDATAIO_TID    = tid;
        bus.iDATAIO_MMUMOD = mmumod;
        bus.iDATAIO_PDT    = pdt;
        bus.iFREE_EX       = 1'b0;
        bus.iMEM_LOCK      = 1'b1;
        bus.iMEM_VALID     = 1'($urandom_range(0, 1));
        bus.iMEM_DATA      = $urandom;
        step();
        bus.iDATAIO_REQ    = 1'b0;
        bus.iDATAIO_ADDR   = $urandom;
        bus.iDATAIO_DATA   = $urandom;
        bus.iDATAIO_TID    = 14'($urandom);
        bus.iDATAIO_PDT    = $urandom;

        for (int i = 0; i <= lock_n; i++) begin
            bus.iMEM_LOCK  = (i < lock_n);
            bus.iMEM_VALID = 1'($urandom_range(0, 1));
            bus.iMEM_DATA  = $urandom;
            bus.iFREE_EX   = (flush_mode == 1 && i == 0);
            check("issue_valid",  32'(bus.oMEM_VALID),   32'h1);
            check("issue_busy",   32'(bus.oDATAIO_BUSY), 32'h1);
            check("issue_addr",   bus.oMEM_ADDR,         addr & 32'hFFFF_FFFC);
            check("issue_be",     32'(bus.oMEM_BE),      32'(xbe));
            check("issue_data",   bus.oMEM_DATA,         rw ? xdata : 32'h0);
            check("issue_rw",     32'(bus.oMEM_RW),      32'(rw));
            check("issue_ctx",    32'({bus.oMEM_TID, bus.oMEM_MMUMOD}), 32'({tid, mmumod}));
            check("issue_pdt",    bus.oMEM_PDT,          pdt);
            check("issue_norsp",  32'({bus.oDATAIO_REQ, bus.oERR_TIMEOUT}), 32'h0);
            step();
            bus.iFREE_EX = 1'b0;
            if (flush_mode == 1 && !rw) break;
        end
        bus.iMEM_VALID = 1'b0;
        bus.iMEM_LOCK  = 1'b1;

        if (rw || flush_mode == 1) begin
            check("post_busy",  32'(bus.oDATAIO_BUSY), 32'h0);
            check("post_valid", 32'(bus.oMEM_VALID),   32'h0);
            check("post_norsp", 32'({bus.oDATAIO_REQ, bus.oERR_TIMEOUT}), 32'h0);
            return;
        end

        if (drain) begin
            for (int i = 0; i < flush_at; i++) begin
                check("wait_busy", 32'(bus.oDATAIO_BUSY), 32'h1);
                step();
            end
            bus.iFREE_EX = 1'b1;
            step();
            bus.iFREE_EX = 1'b0;
        end

        for (int i = 0; i < lat && i < C_TO; i++) begin
            check("wait_busy",  32'(bus.oDATAIO_BUSY), 32'h1);
            check("wait_norsp", 32'({bus.oDATAIO_REQ, bus.oERR_TIMEOUT, bus.oMEM_VALID}), 32'h0);
            step();
        end
        if (lat < C_TO) begin
            bus.iMEM_VALID = 1'b1;
            bus.iMEM_DATA  = rdata;
            step();
            bus.iMEM_VALID = 1'b0;
            x_rsp = !drain; x_err = 1'b0; x_data = rdata;
        end else begin
            x_rsp = !drain; x_err = 1'b1; x_data = 32'h0;
        end
        check("done_rsp",  32'(bus.oDATAIO_REQ),  32'(x_rsp));
        check("done_err",  32'(bus.oERR_TIMEOUT), 32'(x_err));
        check("done_busy", 32'(bus.oDATAIO_BUSY), 32'h0);
        if (x_rsp) check("done_data", bus.oDATAIO_DATA, x_data);
    endtask

    initial begin
        // addr, data, order, rw, lock, lat, rdata, be, mem data
        vecs[0] = '{32'h0000_1003, 32'h0000_00AB, 2'd0, 1'b1, 0, 0, 32'h0,          4'b1000, 32'hAB00_0000};
        vecs[1] = '{32'h0000_2002, 32'h5555_5555, 2'd1, 1'b0, 0, 3, 32'h1122_3344, 4'b1100, 32'h0};
        vecs[2] = '{32'h0000_3000, 32'h0000_0012, 2'd0, 1'b1, 1, 0, 32'h0,          4'b0001, 32'h0000_0012};
        vecs[3] = '{32'h0000_3001, 32'hFFFF_FF34, 2'd0, 1'b1, 0, 0, 32'h0,          4'b0010, 32'hFFFF_3400};
        vecs[4] = '{32'h0000_3002, 32'h0000_0056, 2'd0, 1'b1, 0, 0, 32'h0,          4'b0100, 32'h0056_0000};
        vecs[5] = '{32'h0000_4001, 32'h0000_BEEF, 2'd1, 1'b1, 0, 0, 32'h0,          4'b0110, 32'h00BE_EF00};
        vecs[6] = '{32'h0000_4003, 32'h0000_CAFE, 2'd1, 1'b1, 2, 0, 32'h0,          4'b1000, 32'hFE00_0000};
        vecs[7] = '{32'h0000_5002, 32'h89AB_CDEF, 2'd2, 1'b1, 4, 0, 32'h0,          4'b1111, 32'h89AB_CDEF};
        vecs[8] = '{32'h0000_6001, 32'h0,         2'd2, 1'b0, 1, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0};
        vecs[9] = '{32'h0000_7000, 32'h0000_1234, 2'd1, 1'b1, 0, 0, 32'h0,          4'b0011, 32'h0000_1234};

        iRESET             = 1'b1;
        bus.iFREE_EX       = 1'b0;
        bus.iDATAIO_REQ    = 1'b0;
        bus.iDATAIO_ORDER  = 2'd0;
        bus.iDATAIO_RW     = 1'b0;
        bus.iDATAIO_TID    = 14'h0;
        bus.iDATAIO_MMUMOD = 2'h0;
        bus.iDATAIO_PDT    = 32'h0;
        bus.iDATAIO_ADDR   = 32'h0;
        bus.iDATAIO_DATA   = 32'h0;
        bus.iMEM_LOCK      = 1'b1;
        bus.iMEM_VALID     = 1'b0;
        bus.iMEM_DATA      = 32'h0;
        repeat (2) step();
        check_all_zero("reset");
        iRESET = 1'b0;
        step();

        for (int v = 0; v < 10; v++)
            run_txn(vecs[v].addr, vecs[v].data, vecs[v].order, vecs[v].rw, vecs[v].exp_be,
                    vecs[v].exp_mdata, vecs[v].lock_n, vecs[v].lat, 0, 0, vecs[v].rdata);

        // Read timeout: error and zero-data response together, then one-cycle pulses
        run_txn(32'h0000_8000, 32'h0, 2'd2, 1'b0, 4'b1111, 32'h0, 0, C_TO, 0, 0, 32'h0);
        step();
        check("to_pulse_width", 32'({bus.oDATAIO_REQ, bus.oERR_TIMEOUT}), 32'h0);

        // Flush in WAIT, memory answers two cycles later: no response
        run_txn(32'h0000_9000, 32'h0, 2'd2, 1'b0, 4'b1111, 32'h0, 0, 1, 2, 0, 32'h7777_7777);
        // Flushed read that never gets data: drain times out silently
        run_txn(32'h0000_9004, 32'h0, 2'd2, 1'b0, 4'b1111, 32'h0, 0, C_TO, 2, 1, 32'h0);
        // Flush during a held read command abandons it; during a store it does not
        run_txn(32'h0000_A001, 32'h0, 2'd0, 1'b0, 4'b0010, 32'h0, 2, 0, 1, 0, 32'h0);
        run_txn(32'h0000_A002, 32'h0000_00C3, 2'd0, 1'b1, 4'b0100, 32'h00C3_0000, 2, 0, 1, 0, 32'h0);

        // ORDER=3 is dropped
        bus.iDATAIO_REQ = 1'b1; bus.iDATAIO_ORDER = 2'd3; bus.iDATAIO_RW = 1'b1;
        step();
        bus.iDATAIO_REQ = 1'b0;
        check("drop_busy",  32'(bus.oDATAIO_BUSY), 32'h0);
        check("drop_valid", 32'(bus.oMEM_VALID),   32'h0);
        step();
        check("drop_valid2", 32'(bus.oMEM_VALID),  32'h0);

        // Flush blocks acceptance in IDLE
        bus.iDATAIO_REQ = 1'b1; bus.iDATAIO_ORDER = 2'd2; bus.iFREE_EX = 1'b1;
        step();
        bus.iDATAIO_REQ = 1'b0; bus.iFREE_EX = 1'b0;
        check("flush_idle_busy",  32'(bus.oDATAIO_BUSY), 32'h0);
        check("flush_idle_valid", 32'(bus.oMEM_VALID),   32'h0);

        // Asynchronous reset while waiting for read data
        bus.iDATAIO_REQ = 1'b1; bus.iDATAIO_ORDER = 2'd1; bus.iDATAIO_RW = 1'b0;
        bus.iDATAIO_ADDR = 32'hFFFF_FFF2; bus.iDATAIO_TID = 14'h3ABC;
        bus.iDATAIO_MMUMOD = 2'd3; bus.iDATAIO_PDT = 32'h1234_5678; bus.iMEM_LOCK = 1'b1;
        step();
        bus.iDATAIO_REQ = 1'b0; bus.iMEM_LOCK = 1'b0;
        step();
        bus.iMEM_LOCK = 1'b1;
        check("pre_rst_busy", 32'(bus.oDATAIO_BUSY), 32'h1);
        #2 iRESET = 1'b1;
        #1 check_all_zero("async_rst");
        #2 iRESET = 1'b0;
        bus.iMEM_VALID = 1'b1; bus.iMEM_DATA = 32'hBAD0_BAD0;
        step();
        bus.iMEM_VALID = 1'b0;
        check("rst_late_rsp",  32'(bus.oDATAIO_REQ),  32'h0);
        check("rst_late_busy", 32'(bus.oDATAIO_BUSY), 32'h0);
        step();
        check("rst_late_rsp2", 32'(bus.oDATAIO_REQ),  32'h0);

        // Random transactions against the model
        for (int t = 0; t < 200; t++) begin
            logic [31:0] a  = $urandom;
            logic [31:0] d  = $urandom;
            logic [1:0]  o  = 2'($urandom_range(0, 2));
            logic        rw = 1'($urandom_range(0, 1));
            int          fm = ($urandom_range(0, 5) == 0) ? 1 :
                              (($urandom_range(0, 4) == 0) ? 2 : 0);
            run_txn(a, d, o, rw, ref_be(o, a[1:0]), ref_wdata(d, o, a[1:0]),
                    $urandom_range(0, 3), $urandom_range(0, 5), fm,
                    $urandom_range(0, 2), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dataio_mem_responder.md
DATAIO_MEM_RESPONDER -- requirements
Module: dataio_mem_responder

Interface
REQ-001 Parameter P_TIMEOUT, default 255: maximum number of cycles a read waits for memory data; legal range 1..255.
REQ-002 iCLOCK  in  1  system clock; all state updates on the rising edge.
REQ-003 iRESET  in  1  reset; asynchronous, active-high.
REQ-004 iFREE_EX  in  1  pipeline flush.
REQ-005 iDATAIO_REQ  in  1  request from the load/store unit.
REQ-006 oDATAIO_BUSY  out  1  responder cannot accept a request.
REQ-007 iDATAIO_ORDER  in  2  transfer size: 0=byte, 1=halfword, 2=word, 3=none.
REQ-008 iDATAIO_RW  in  1  direction: 0=read, 1=write.
REQ-009 iDATAIO_TID  in  14 / iDATAIO_MMUMOD  in  2 / iDATAIO_PDT  in  32  MMU context.
REQ-010 iDATAIO_ADDR  in  32  byte address; iDATAIO_DATA  in  32  write data, right-justified.
REQ-011 oDATAIO_REQ  out  1  read data valid, one-cycle pulse; oDATAIO_DATA  out  32  raw aligned word.
REQ-012 oMEM_VALID  out  1 / iMEM_LOCK  in  1  memory command handshake.
REQ-013 oMEM_RW  out  1 / oMEM_ADDR  out  32 (bits[1:0]=0) / oMEM_BE  out  4 / oMEM_DATA  out  32  memory command fields.
REQ-014 oMEM_TID  out  14 / oMEM_MMUMOD  out  2 / oMEM_PDT  out  32  registered copies of the request context.
REQ-015 iMEM_VALID  in  1 / iMEM_DATA  in  32  memory read return.
REQ-016 oERR_TIMEOUT  out  1  one-cycle pulse when a read times out.

Function
REQ-017 States: IDLE, ISSUE, WAIT, DRAIN; oDATAIO_BUSY SHALL equal (state != IDLE), combinationally.
REQ-018 A request is accepted when iDATAIO_REQ=1 and state=IDLE and iFREE_EX=0; on acceptance all fields are registered and the next state is ISSUE, except ORDER=3, which is accepted and dropped (state remains IDLE, no memory command).
REQ-019 oMEM_ADDR SHALL equal {ADDR[31:2],2'b00}; lane index k = ADDR[1:0].
REQ-020 Byte-enable: byte -> 4'b0001<<k; halfword -> (4'b0011<<k) truncated to 4 bits (k=3 gives 4'b1000); word -> 4'b1111 regardless of k.
REQ-021 Write data: byte/halfword -> iDATAIO_DATA<<(8k), truncated to 32 bits; word -> unshifted. Read commands drive BE as above and oMEM_DATA=0.
REQ-022 ISSUE: oMEM_VALID=1 with stable fields until the cycle in which iMEM_LOCK=0 (handshake cycle). After a write handshake the next state is IDLE; after a read handshake the next state is WAIT.
REQ-023 WAIT: on iMEM_VALID=1, the next cycle has oDATAIO_REQ=1, oDATAIO_DATA=iMEM_DATA (unshifted, unmasked) and state IDLE. Read latency from acceptance is therefore at least 3 cycles.
REQ-024 A new request MAY be accepted in the same cycle that oDATAIO_REQ pulses.
REQ-025 8-bit timeout counter: cleared on entry to WAIT/DRAIN, increments every cycle without iMEM_VALID; on reaching P_TIMEOUT the state goes to IDLE and oERR_TIMEOUT pulses.
- From WAIT, the same timeout cycle also pulses oDATAIO_REQ with data 32'h0.
- From DRAIN, no oDATAIO_REQ pulse.
REQ-026 Flush, by state:
- ISSUE with a write: the store still completes.
- ISSUE with a read: abandoned; next state IDLE, oMEM_VALID drops.
- WAIT: next state DRAIN.
- IDLE: no acceptance that cycle.
REQ-027 DRAIN: on iMEM_VALID, return to IDLE with no oDATAIO_REQ; oDATAIO_REQ SHALL never pulse for a flushed read.
REQ-028 iMEM_VALID in IDLE or ISSUE SHALL be ignored.
REQ-029 oDATAIO_REQ, oMEM_VALID and oERR_TIMEOUT SHALL be registered, glitch-free outputs.

Reset
REQ-030 iRESET=1 forces, asynchronously: state IDLE; counter 0; oDATAIO_REQ, oMEM_VALID, oERR_TIMEOUT = 0; oDATAIO_DATA, oMEM_ADDR, oMEM_DATA, oMEM_PDT = 0; oMEM_BE, oMEM_TID, oMEM_MMUMOD, oMEM_RW = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no response pulse; a late iMEM_VALID after reset is ignored.

Verification
REQ-032 Byte write: ADDR=0x1003, DATA=0xAB, ORDER=0, RW=1, iMEM_LOCK=0 -> next cycle oMEM_VALID=1, ADDR=0x1000, BE=1000, DATA=0xAB000000; BUSY low one cycle later.
REQ-033 Halfword read: ADDR=0x2002; memory returns 0x11223344 three cycles after the handshake -> BE=1100; oDATAIO_REQ pulses once with 0x11223344, one cycle after iMEM_VALID.
REQ-034 iMEM_LOCK held for 4 cycles during a word write -> oMEM_VALID and all fields stable for 5 cycles; BUSY=1 throughout.
REQ-035 iFREE_EX during WAIT, then iMEM_VALID 2 cycles later -> no oDATAIO_REQ pulse; BUSY drops the cycle after iMEM_VALID.
REQ-036 P_TIMEOUT=4, read with no iMEM_VALID -> oERR_TIMEOUT and oDATAIO_REQ (data 0) pulse together; state returns to IDLE.
REQ-037 ORDER=3 request -> no oMEM_VALID, BUSY stays 0; iRESET pulse in WAIT -> all outputs 0, subsequent iMEM_VALID ignored.
